// File: rtl/i2c_bus_arbiter.sv
// i2c_bus_arbiter: round-robin sharing of one i2c_controller between NREQ requesters.
// Optional byte/drain watchdog is compiled in when I2C_ARB_TIMEOUT_EN is defined.
module i2c_bus_arbiter #(
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 8
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_addr,
    input  logic [4*NREQ-1:0] req_len,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic              err,
    output logic              enable,
    output logic [7:0]        slave_address,
    input  logic              byte_tx_done,
    input  logic              byte_rx_done,
    input  logic              ctrl_idle
);
    localparam int IW = $clog2(NREQ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, GAP} state_t;

    state_t          state, state_n;
    logic [IW-1:0]   rr_ptr, rr_ptr_n, winner, winner_n, pick;
    logic [NREQ-1:0] rot, gnt_n;
    logic [4:0]      remaining, remaining_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            status_err, status_err_n;
    logic            done_n, err_n, enable_n, byte_evt, tmo_hit;
    logic [7:0]      addr_n;
    logic [7:0]      addr_arr [NREQ];
    logic [3:0]      len_arr  [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign addr_arr[i] = req_addr[8*i +: 8];
        assign len_arr[i]  = req_len[4*i +: 4];
    end

    assign byte_evt = byte_tx_done | byte_rx_done;
    // requests rotated so bit 0 is rr_ptr; lowest set bit wins
    assign rot = NREQ'({req, req} >> rr_ptr);

    always_comb begin
        pick = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) pick = IW'((int'(rr_ptr) + k) % NREQ);
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    assign tmo_hit = tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    // counts cycles since RUN/DRAIN entry or the last byte event
    always_ff @(posedge core_clk)
        tmo_cnt <= (!rst_n || state_n != state || state == IDLE || state == GAP ||
                    (state == RUN && byte_evt)) ? '0 : tmo_cnt + 1'b1;
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_n      = state;
        rr_ptr_n     = rr_ptr;
        winner_n     = winner;
        remaining_n  = remaining;
        gap_cnt_n    = gap_cnt;
        status_err_n = status_err;
        gnt_n        = gnt;
        addr_n       = slave_address;
        enable_n     = enable;
        done_n       = 1'b0;
        err_n        = 1'b0;
        case (state)
            IDLE: if (|req) begin
                winner_n     = pick;
                gnt_n        = NREQ'(1) << pick;
                addr_n       = addr_arr[pick];
                remaining_n  = (len_arr[pick] == 4'd0) ? 5'd16 : {1'b0, len_arr[pick]};
                enable_n     = 1'b1;
                status_err_n = 1'b0;
                state_n      = RUN;
            end
            RUN: if (byte_evt && remaining == 5'd1) begin
                remaining_n = '0;
                enable_n    = 1'b0;
                state_n     = DRAIN;
            end else if (!req[winner] || (tmo_hit && !byte_evt)) begin
                enable_n     = 1'b0;
                status_err_n = 1'b1;
                state_n      = DRAIN;
            end else if (byte_evt) begin
                remaining_n = remaining - 5'd1;
            end
            DRAIN: if (ctrl_idle || tmo_hit) begin
                done_n    = 1'b1;
                err_n     = status_err | !ctrl_idle;
                gnt_n     = '0;
                rr_ptr_n  = IW'((int'(winner) + 1) % NREQ);
                gap_cnt_n = GW'(GAP_CYCLES - 1);
                state_n   = GAP;
            end
            GAP: begin
                state_n   = (gap_cnt == '0) ? IDLE : GAP;
                gap_cnt_n = (gap_cnt == '0) ? gap_cnt : gap_cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            winner        <= '0;
            remaining     <= '0;
            gap_cnt       <= '0;
            status_err    <= 1'b0;
            gnt           <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            enable        <= 1'b0;
            slave_address <= 8'h00;
        end else begin
            state         <= state_n;
            rr_ptr        <= rr_ptr_n;
            winner        <= winner_n;
            remaining     <= remaining_n;
            gap_cnt       <= gap_cnt_n;
            status_err    <= status_err_n;
            gnt           <= gnt_n;
            done          <= done_n;
            err           <= err_n;
            enable        <= enable_n;
            slave_address <= addr_n;
        end
    end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// tb_i2c_bus_arbiter: randomized self-checking bench with a transaction-level round-robin model.
module tb_i2c_bus_arbiter;
    localparam int NREQ = 4;
    localparam int GAP  = 8;
    localparam int TMO  = 16;

    logic              core_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_addr = '0;
    logic [4*NREQ-1:0] req_len = '0;
    logic [NREQ-1:0]   gnt;
    logic              done, err, enable;
    logic [7:0]        slave_address;
    logic              byte_tx_done = 1'b0, byte_rx_done = 1'b0, ctrl_idle = 1'b1;

    int checks = 0, failures = 0;
    int rr = 0;
    logic [7:0] exp_addr [NREQ];
    int         exp_len  [NREQ];

    i2c_bus_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)) dut (
        .core_clk(core_clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_len(req_len),
        .gnt(gnt), .done(done), .err(err), .enable(enable), .slave_address(slave_address),
        .byte_tx_done(byte_tx_done), .byte_rx_done(byte_rx_done), .ctrl_idle(ctrl_idle)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick();
        @(negedge core_clk);
    endtask

    function automatic int model_pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++)
            if (m[2'((rr + k) % NREQ)]) return (rr + k) % NREQ;
        return 0;
    endfunction

    task automatic set_req(input int i, input logic [7:0] a, input logic [3:0] l);
        req_addr[8*i +: 8] = a;
        req_len[4*i +: 4]  = l;
        exp_addr[i] = a;
        exp_len[i]  = (l == 4'd0) ? 16 : int'(l);
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt === '0 && cyc < 100) begin tick(); cyc++; end
        ctrl_idle = 1'b0;
    endtask

    // mode 0: tx strobes, 1: rx strobes, 2: both at once
    task automatic run_bytes(input int n, input int mode, output int bad, output logic en_last);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) begin tick(); if (enable !== 1'b1) bad++; end
            byte_tx_done = (mode != 1);
            byte_rx_done = (mode != 0);
            tick();
            byte_tx_done = 1'b0;
            byte_rx_done = 1'b0;
            if (i < n - 1 && enable !== 1'b1) bad++;
        end
        en_last = enable;
    endtask

    task automatic finish_txn(output int lat, output int dcnt, output logic e, output logic [NREQ-1:0] g);
        repeat ($urandom_range(0, 3)) tick();
        ctrl_idle = 1'b1;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        e = err;
        g = gnt;
        dcnt = (done === 1'b1) ? 1 : 0;
        tick();
        if (done === 1'b1) dcnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; ctrl_idle = 1'b1;
        repeat (3) tick();
        checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_done_err got=%b%b exp=00", done, err); end
        checks++; if (slave_address !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", slave_address); end
        rst_n = 1'b1; rr = 0;
        tick();
    endtask

    task automatic test_single_write();
        int c, bad, lat, dc; logic en, e; logic [NREQ-1:0] g;
        set_req(0, 8'hA0, 4'd2);
        req = 4'b0001;
        wait_gnt(c);
        checks++; if (c != 1) begin failures++; $display("FAIL single_latency got=%0d exp=1", c); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (enable !== 1'b1) begin failures++; $display("FAIL single_enable got=%b exp=1", enable); end
        checks++; if (slave_address !== 8'hA0) begin failures++; $display("FAIL single_addr got=%h exp=a0", slave_address); end
        run_bytes(2, 0, bad, en);
        checks++; if (bad != 0) begin failures++; $display("FAIL single_early_drop got=%0d exp=0", bad); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL single_enable_fall got=%b exp=0", en); end
        finish_txn(lat, dc, e, g);
        checks++; if (lat != 1 || dc != 1) begin failures++; $display("FAIL single_done got=lat%0d/cnt%0d exp=lat1/cnt1", lat, dc); end
        checks++; if (e !== 1'b0 || g !== '0) begin failures++; $display("FAIL single_err_gnt got=%b/%b exp=0/0000", e, g); end
        req = '0; rr = 1;
    endtask

    task automatic test_round_robin();
        int c, bad, lat, dc, w; logic en, e; logic [NREQ-1:0] g;
        rst_n = 1'b0; ctrl_idle = 1'b1; tick(); tick(); rst_n = 1'b1; rr = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom_range(0, 255)), 4'd1);
        req = 4'b1011;
        for (int t = 0; t < 4; t++) begin
            w = model_pick(req);
            wait_gnt(c);
            if (t > 0) begin
                checks++; if (c != GAP) begin failures++; $display("FAIL rr_gap%0d got=%0d exp=%0d", t, c, GAP); end
            end
            checks++; if (gnt !== NREQ'(1) << w) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", t, gnt, NREQ'(1) << w); end
            checks++; if (slave_address !== exp_addr[w]) begin failures++; $display("FAIL rr_addr%0d got=%h exp=%h", t, slave_address, exp_addr[w]); end
            run_bytes(1, $urandom_range(0, 2), bad, en);
            checks++; if (en !== 1'b0) begin failures++; $display("FAIL rr_enable%0d got=%b exp=0", t, en); end
            finish_txn(lat, dc, e, g);
            checks++; if (dc != 1 || e !== 1'b0) begin failures++; $display("FAIL rr_done%0d got=cnt%0d/err%b exp=cnt1/err0", t, dc, e); end
            rr = (w + 1) % NREQ;
        end
        req = '0;
    endtask

    task automatic test_len0();
        int c, bad, lat, dc; logic en, e; logic [NREQ-1:0] g;
        set_req(2, 8'hA1, 4'd0);
        req = 4'b0100;
        wait_gnt(c);
        checks++; if (gnt !== 4'b0100 || slave_address !== 8'hA1) begin failures++; $display("FAIL len0_grant got=%b/%h exp=0100/a1", gnt, slave_address); end
        run_bytes(16, 1, bad, en);
        checks++; if (bad != 0) begin failures++; $display("FAIL len0_early_drop got=%0d exp=0", bad); end
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL len0_enable_fall got=%b exp=0", en); end
        finish_txn(lat, dc, e, g);
        checks++; if (dc != 1 || e !== 1'b0) begin failures++; $display("FAIL len0_done got=cnt%0d/err%b exp=cnt1/err0", dc, e); end
        req = '0; rr = 3;
    endtask

    task automatic test_simultaneous();
        int c, bad, lat, dc; logic en, e; logic [NREQ-1:0] g;
        set_req(0, 8'h3C, 4'd2);
        req = 4'b0001;
        wait_gnt(c);
        run_bytes(1, 2, bad, en);
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL simul_single_count got=%b exp=1", en); end
        run_bytes(1, 2, bad, en);
        checks++; if (en !== 1'b0) begin failures++; $display("FAIL simul_enable_fall got=%b exp=0", en); end
        finish_txn(lat, dc, e, g);
        checks++; if (dc != 1 || e !== 1'b0) begin failures++; $display("FAIL simul_done got=cnt%0d/err%b exp=cnt1/err0", dc, e); end
        req = '0; rr = 1;
    endtask

    task automatic test_abort();
        int c, bad, lat, dc; logic en, e; logic [NREQ-1:0] g;
        set_req(1, 8'h52, 4'd3);
        req = 4'b0010;
        wait_gnt(c);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL abort_gnt got=%b exp=0010", gnt); end
        run_bytes(1, 0, bad, en);
        checks++; if (en !== 1'b1) begin failures++; $display("FAIL abort_mid_enable got=%b exp=1", en); end
        req[1] = 1'b0;
        tick();
        checks++; if (enable !== 1'b0) begin failures++; $display("FAIL abort_enable got=%b exp=0", enable); end
        finish_txn(lat, dc, e, g);
        checks++; if (lat != 1 || dc != 1) begin failures++; $display("FAIL abort_done got=lat%0d/cnt%0d exp=lat1/cnt1", lat, dc); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL abort_err got=%b exp=1", e); end
        rr = 2;
    endtask

    task automatic test_random();
        int c, bad, lat, dc, w; logic en, e; logic [NREQ-1:0] g;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
            req = 4'($urandom_range(1, 15));
            w = model_pick(req);
            wait_gnt(c);
            if (t > 0) begin
                checks++; if (c != GAP) begin failures++; $display("FAIL rand_gap%0d got=%0d exp=%0d", t, c, GAP); end
            end
            checks++; if (gnt !== NREQ'(1) << w) begin failures++; $display("FAIL rand_gnt%0d got=%b exp=%b", t, gnt, NREQ'(1) << w); end
            checks++; if (slave_address !== exp_addr[w]) begin failures++; $display("FAIL rand_addr%0d got=%h exp=%h", t, slave_address, exp_addr[w]); end
            run_bytes(exp_len[w], $urandom_range(0, 2), bad, en);
            checks++; if (bad != 0 || en !== 1'b0) begin failures++; $display("FAIL rand_enable%0d got=bad%0d/en%b exp=bad0/en0", t, bad, en); end
            checks++; if (slave_address !== exp_addr[w]) begin failures++; $display("FAIL rand_addr_stable%0d got=%h exp=%h", t, slave_address, exp_addr[w]); end
            finish_txn(lat, dc, e, g);
            checks++; if (lat != 1 || dc != 1 || e !== 1'b0) begin failures++; $display("FAIL rand_done%0d got=lat%0d/cnt%0d/err%b exp=lat1/cnt1/err0", t, lat, dc, e); end
            rr = (w + 1) % NREQ;
        end
        req = '0;
    endtask

    task automatic test_reset_mid_run();
        int c, bad; logic en;
        set_req(3, 8'hEE, 4'd4);
        req = 4'b1000;
        wait_gnt(c);
        run_bytes(1, 0, bad, en);
        rst_n = 1'b0;
        tick();
        checks++; if (gnt !== '0 || enable !== 1'b0) begin failures++; $display("FAIL midrst_gnt_en got=%b/%b exp=0000/0", gnt, enable); end
        checks++; if (done !== 1'b0 || err !== 1'b0 || slave_address !== 8'h00) begin failures++; $display("FAIL midrst_outs got=%b%b/%h exp=00/00", done, err, slave_address); end
        req = '0; ctrl_idle = 1'b1; rst_n = 1'b1; rr = 0;
        tick();
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int c; logic e;
        set_req(0, 8'h10, 4'd2);
        req = 4'b0001;
        wait_gnt(c);
        c = 0;
        while (enable !== 1'b0 && c < 100) begin tick(); c++; end
        checks++; if (c != TMO) begin failures++; $display("FAIL tmo_run got=%0d exp=%0d", c, TMO); end
        c = 0;
        while (done !== 1'b1 && c < 100) begin tick(); c++; end
        e = err;
        checks++; if (c != TMO || e !== 1'b1) begin failures++; $display("FAIL tmo_drain got=%0d/err%b exp=%0d/err1", c, e, TMO); end
        req = '0; ctrl_idle = 1'b1; rr = 1;
        repeat (GAP + 2) tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_len0();
        test_simultaneous();
        test_abort();
        test_random();
        test_reset_mid_run();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
